// File: rtl/ask_threshold_controller.sv
// Adaptive peak/valley threshold programmer for the ASK detector; thresholds update 1 clk after window close.
// Backpressure: i_tready = enable. Optional ASK_THRESH_MANUAL_OVERRIDE_EN adds manual threshold override.
module ask_threshold_controller #(
  parameter int WIDTH        = 16,
  parameter int WINDOW_LOG2  = 10,
  parameter int HYST_SHIFT   = 2,
  parameter int MIN_SPAN     = 64,
  parameter int LOSS_WINDOWS = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             enable,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] upthreshold,
  output logic [WIDTH-1:0] downthreshold,
  output logic             thresh_valid,
  output logic             lock,
  output logic             win_strobe
`ifdef ASK_THRESH_MANUAL_OVERRIDE_EN
  ,
  input  logic             manual_en,
  input  logic [WIDTH-1:0] manual_up,
  input  logic [WIDTH-1:0] manual_down
`endif
);

  localparam int W2 = WIDTH + 2;
  localparam logic [WIDTH-1:0] C_MAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] C_MIN = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic {S_ACQUIRE, S_TRACK} state_t;

  state_t                   r_state, w_state_nxt;
  logic [WINDOW_LOG2-1:0]   r_cnt;
  logic signed [WIDTH-1:0]  r_max, r_min, w_max, w_min, w_smp;
  logic [WIDTH-1:0]         r_up, r_down, w_up_nxt, w_down_nxt;
  logic                     r_tv, w_tv_nxt;
  logic                     r_strobe, w_strobe_nxt;
  logic [3:0]               r_weak, w_weak_nxt, w_weak_inc;
  logic                     w_accept, w_first, w_close, w_qual;
  logic signed [W2-1:0]     w_max_e, w_min_e, w_span, w_mid, w_hyst, w_up_raw, w_down_raw;

  function automatic logic [WIDTH-1:0] sat(input logic signed [W2-1:0] v);
    if (v > $signed({2'b00, C_MAX}))      return C_MAX;
    else if (v < $signed({2'b11, C_MIN})) return C_MIN;
    else                                  return v[WIDTH-1:0];
  endfunction

  assign i_tready = enable;
  assign w_accept = i_tvalid & enable;
  assign w_first  = (r_cnt == '0);
  assign w_close  = w_accept & (r_cnt == '1);
  assign w_smp    = $signed(i_tdata);

  // Extrema including the current sample, so the closing sample counts.
  assign w_max = (w_first || (w_smp > r_max)) ? w_smp : r_max;
  assign w_min = (w_first || (w_smp < r_min)) ? w_smp : r_min;

  assign w_max_e    = $signed({{2{w_max[WIDTH-1]}}, w_max});
  assign w_min_e    = $signed({{2{w_min[WIDTH-1]}}, w_min});
  assign w_span     = w_max_e - w_min_e;
  assign w_mid      = (w_max_e + w_min_e) >>> 1;
  assign w_hyst     = w_span >>> HYST_SHIFT;
  assign w_up_raw   = w_mid + w_hyst;
  assign w_down_raw = w_mid - w_hyst;
  assign w_qual     = (w_span >= $signed(W2'(MIN_SPAN)));
  assign w_weak_inc = r_weak + 4'd1;

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_state <= S_ACQUIRE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_up_nxt     = r_up;
    w_down_nxt   = r_down;
    w_tv_nxt     = r_tv;
    w_weak_nxt   = r_weak;
    w_strobe_nxt = 1'b0;
    if (w_close) begin
      w_strobe_nxt = 1'b1;
      if (w_qual) begin
        w_up_nxt    = sat(w_up_raw);
        w_down_nxt  = sat(w_down_raw);
        w_tv_nxt    = 1'b1;
        w_weak_nxt  = 4'd0;
        w_state_nxt = S_TRACK;
      end else if (r_state == S_TRACK) begin
        if (w_weak_inc == 4'(LOSS_WINDOWS)) begin
          w_weak_nxt  = 4'd0;
          w_state_nxt = S_ACQUIRE;
        end else begin
          w_weak_nxt  = w_weak_inc;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_cnt    <= '0;
      r_max    <= '0;
      r_min    <= '0;
      r_up     <= C_MAX;
      r_down   <= C_MIN;
      r_tv     <= 1'b0;
      r_weak   <= 4'd0;
      r_strobe <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt <= r_cnt + WINDOW_LOG2'(1);
        r_max <= w_max;
        r_min <= w_min;
      end
      r_up     <= w_up_nxt;
      r_down   <= w_down_nxt;
      r_tv     <= w_tv_nxt;
      r_weak   <= w_weak_nxt;
      r_strobe <= w_strobe_nxt;
    end
  end

  assign win_strobe = r_strobe;

`ifdef ASK_THRESH_MANUAL_OVERRIDE_EN
  logic [WIDTH-1:0] r_up_o, r_down_o;
  logic             r_tv_o, r_lock_o;

  // Output stage follows the internal next-state, so dropping manual_en reverts in one clock.
  always_ff @(posedge clk) begin
    if (!reset_n || clear) begin
      r_up_o   <= C_MAX;
      r_down_o <= C_MIN;
      r_tv_o   <= 1'b0;
      r_lock_o <= 1'b0;
    end else if (manual_en) begin
      r_up_o   <= manual_up;
      r_down_o <= manual_down;
      r_tv_o   <= 1'b1;
      r_lock_o <= 1'b1;
    end else begin
      r_up_o   <= w_up_nxt;
      r_down_o <= w_down_nxt;
      r_tv_o   <= w_tv_nxt;
      r_lock_o <= (w_state_nxt == S_TRACK);
    end
  end

  assign upthreshold   = r_up_o;
  assign downthreshold = r_down_o;
  assign thresh_valid  = r_tv_o;
  assign lock          = r_lock_o;
`else
  assign upthreshold   = r_up;
  assign downthreshold = r_down;
  assign thresh_valid  = r_tv;
  assign lock          = (r_state == S_TRACK);
`endif

endmodule

// File: tb/tb_ask_threshold_controller.sv
// Randomized + directed bench for ask_threshold_controller; two instances differ only in HYST_SHIFT (2 and 0).
module tb_ask_threshold_controller;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n, clear, enable, i_tvalid;
  logic [15:0] i_tdata;
  logic        rdy_a, rdy_b, tv_a, tv_b, lk_a, lk_b, st_a, st_b;
  logic [15:0] up_a, dn_a, up_b, dn_b;
`ifdef ASK_THRESH_MANUAL_OVERRIDE_EN
  logic        manual_en;
  logic [15:0] manual_up, manual_down;
`endif

  ask_threshold_controller #(.WIDTH(16), .WINDOW_LOG2(3), .HYST_SHIFT(2), .MIN_SPAN(64), .LOSS_WINDOWS(4)) dut_a (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(rdy_a),
    .upthreshold(up_a), .downthreshold(dn_a), .thresh_valid(tv_a), .lock(lk_a), .win_strobe(st_a)
`ifdef ASK_THRESH_MANUAL_OVERRIDE_EN
    , .manual_en(manual_en), .manual_up(manual_up), .manual_down(manual_down)
`endif
  );

  ask_threshold_controller #(.WIDTH(16), .WINDOW_LOG2(3), .HYST_SHIFT(0), .MIN_SPAN(64), .LOSS_WINDOWS(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .clear(clear), .enable(enable),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(rdy_b),
    .upthreshold(up_b), .downthreshold(dn_b), .thresh_valid(tv_b), .lock(lk_b), .win_strobe(st_b)
`ifdef ASK_THRESH_MANUAL_OVERRIDE_EN
    , .manual_en(manual_en), .manual_up(manual_up), .manual_down(manual_down)
`endif
  );

  // Reference model: window kept as a list of accepted samples.
  int q[$];
  int m_up[2], m_dn[2];
  int m_weak;
  bit m_tv, m_lock, m_strobe, m_man;
  int m_mu, m_md;
  int n_checks = 0, n_err = 0;
  int shifts[2] = '{2, 0};

  task automatic check(input string tag, input logic signed [31:0] act, input logic signed [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int clip(input int v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  task automatic close_window();
    int mx, mn, span, s, mid, h;
    mx = q[0];
    mn = q[0];
    foreach (q[i]) begin
      if (q[i] > mx) mx = q[i];
      if (q[i] < mn) mn = q[i];
    end
    span = mx - mn;
    s    = mx + mn;
    mid  = (s >= 0) ? s / 2 : -((1 - s) / 2);
    m_strobe = 1'b1;
    if (span >= 64) begin
      for (int k = 0; k < 2; k++) begin
        h        = span / (1 << shifts[k]);
        m_up[k]  = clip(mid + h);
        m_dn[k]  = clip(mid - h);
      end
      m_tv   = 1'b1;
      m_lock = 1'b1;
      m_weak = 0;
    end else if (m_lock) begin
      m_weak++;
      if (m_weak == 4) begin
        m_lock = 1'b0;
        m_weak = 0;
      end
    end
    q.delete();
  endtask

  task automatic model_update(input bit rn, input bit clr, input bit en, input bit v, input int ds);
    m_strobe = 1'b0;
    if (!rn || clr) begin
      q.delete();
      m_up   = '{32767, 32767};
      m_dn   = '{-32768, -32768};
      m_tv   = 1'b0;
      m_lock = 1'b0;
      m_weak = 0;
      m_man  = 1'b0;
    end else begin
      if (en && v) begin
        q.push_back(ds);
        if (q.size() == 8) close_window();
      end
`ifdef ASK_THRESH_MANUAL_OVERRIDE_EN
      m_man = manual_en;
      m_mu  = int'($signed(manual_up));
      m_md  = int'($signed(manual_down));
`endif
    end
  endtask

  task automatic compare_all(input bit en);
    check("tready_a", rdy_a, en);
    check("tready_b", rdy_b, en);
    check("strobe_a", st_a, m_strobe);
    check("strobe_b", st_b, m_strobe);
    check("lock_a", lk_a, m_man ? 1 : m_lock);
    check("lock_b", lk_b, m_man ? 1 : m_lock);
    check("tvalid_a", tv_a, m_man ? 1 : m_tv);
    check("tvalid_b", tv_b, m_man ? 1 : m_tv);
    check("up_a", $signed(up_a), m_man ? m_mu : m_up[0]);
    check("down_a", $signed(dn_a), m_man ? m_md : m_dn[0]);
    check("up_b", $signed(up_b), m_man ? m_mu : m_up[1]);
    check("down_b", $signed(dn_b), m_man ? m_md : m_dn[1]);
  endtask

  task automatic cycle(input bit rn, input bit clr, input bit en, input bit v, input int d);
    logic signed [15:0] s16;
    s16      = d[15:0];
    reset_n  = rn;
    clear    = clr;
    enable   = en;
    i_tvalid = v;
    i_tdata  = s16;
    @(posedge clk);
    model_update(rn, clr, en, v, int'(s16));
    #1;
    compare_all(en);
  endtask

  task automatic send(input int d);
    cycle(1'b1, 1'b0, 1'b1, 1'b1, d);
  endtask

  task automatic do_reset();
    repeat (2) cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
  endtask

  task automatic lock_window(input int a);
    for (int i = 0; i < 8; i++) send((i % 2 == 0) ? a : -a);
  endtask

  initial begin
    int amp, d;
    bit rn, clr, en, v;
    reset_n = 1'b0; clear = 1'b0; enable = 1'b0; i_tvalid = 1'b0; i_tdata = '0;
`ifdef ASK_THRESH_MANUAL_OVERRIDE_EN
    manual_en = 1'b0; manual_up = '0; manual_down = '0;
`endif
    repeat (3) cycle(1'b0, 1'b0, 1'b1, 1'b0, 0);
    check("rst_up", $signed(up_a), 32767);
    check("rst_down", $signed(dn_a), -32768);

    lock_window(1000);
    check("t1_strobe", st_a, 1);
    check("t1_up", $signed(up_a), 500);
    check("t1_down", $signed(dn_a), -500);
    check("t1_lock", lk_a, 1);
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("t1_strobe_pulse", st_a, 0);

    do_reset();
    for (int i = 0; i < 8; i++) send((i == 7) ? 40 : 10 + 4 * i);
    check("t2_strobe", st_a, 1);
    check("t2_up", $signed(up_a), 32767);
    check("t2_lock", lk_a, 0);
    check("t2_tvalid", tv_a, 0);

    do_reset();
    lock_window(1000);
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < 8; i++) send(5);
      if (w == 2) check("t3_lock_held", lk_a, 1);
    end
    check("t3_lock_lost", lk_a, 0);
    check("t3_up_held", $signed(up_a), 500);
    check("t3_tvalid", tv_a, 1);

    do_reset();
    send(32767); send(-32768);
    for (int i = 0; i < 6; i++) send(0);
    check("t4_up_a", $signed(up_a), 16382);
    check("t4_down_a", $signed(dn_a), -16384);
    check("t4_up_sat", $signed(up_b), 32767);
    check("t4_down_sat", $signed(dn_b), -32768);

    for (int i = 0; i < 7; i++) send((i % 2 == 0) ? 1000 : -1000);
    cycle(1'b1, 1'b1, 1'b1, 1'b1, 1000);
    check("t5_no_strobe", st_a, 0);
    check("t5_up_rst", $signed(up_a), 32767);
    for (int i = 0; i < 7; i++) send((i % 2 == 0) ? 1000 : -1000);
    check("t5_no_early", st_a, 0);
    send(-1000);
    check("t5_strobe", st_a, 1);
    check("t5_up", $signed(up_a), 500);

    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, 1'b0, 1'b0, 1'b1, 30000);
      send((i % 2 == 0) ? 2000 : -2000);
    end
    check("t6_up", $signed(up_a), 1000);

`ifdef ASK_THRESH_MANUAL_OVERRIDE_EN
    lock_window(1000);
    manual_en = 1'b1; manual_up = 16'd300; manual_down = -16'sd200;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("man_up", $signed(up_a), 300);
    check("man_down", $signed(dn_a), -200);
    check("man_lock", lk_a, 1);
    manual_en = 1'b0;
    cycle(1'b1, 1'b0, 1'b1, 1'b0, 0);
    check("man_revert", $signed(up_a), 500);
`endif

    amp = 300;
    for (int n = 0; n < 1500; n++) begin
      if (n % 40 == 0) begin
        case ($urandom_range(0, 2))
          0:       amp = 20;
          1:       amp = 300;
          default: amp = 60000;
        endcase
      end
      d = int'($urandom_range(0, amp)) - amp / 2;
      if ($urandom_range(0, 31) == 0) d = ($urandom_range(0, 1) == 1) ? 32767 : -32768;
      rn  = ($urandom_range(0, 299) != 0);
      clr = ($urandom_range(0, 99) == 0);
      en  = ($urandom_range(0, 7) != 0);
      v   = ($urandom_range(0, 3) != 0);
      cycle(rn, clr, en, v, d);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
